// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned DEF_DEPTH        = 4;
  localparam int unsigned DEF_STARVE_LIMIT = 8;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // One register-file write: destination and data.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage : rf_arb_pkg

// File: rtl/rf_wr_fifo.sv
// MDU result FIFO: DEPTH entries of wr_req_t with per-slot valid bits so the
// arbiter can search all queued destinations for pending-write hazards.
//   clk, rst           clock, async active-low reset
//   push, push_req     enqueue request (ignored when full)
//   pop                dequeue head (ignored when empty)
//   head               oldest entry
//   count              occupancy 0..DEPTH
//   entry_valid/addr   per-slot occupancy and destination register
module rf_wr_fifo
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  wr_req_t                          push_req,
  input  logic                             pop,
  output wr_req_t                          head,
  output logic [$clog2(DEPTH):0]           count,
  output logic [DEPTH-1:0]                 entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]     entry_addr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wr_req_t          mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [DEPTH-1:0] valid_nxt;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Slot valid bits follow the pointers; pop and push never hit the same slot.
  always_comb begin
    valid_nxt = entry_valid;
    if (do_pop)  valid_nxt[rd_ptr] = 1'b0;
    if (do_push) valid_nxt[wr_ptr] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) entry_addr[i] = mem[i].addr;
  end

  // Pointers, count and valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      entry_valid <= valid_nxt;
      if (do_push) wr_ptr <= PW'(wr_ptr + 1'b1);
      if (do_pop)  rd_ptr <= PW'(rd_ptr + 1'b1);
      case ({do_push, do_pop})
        2'b10:   count <= CW'(count + 1'b1);
        2'b01:   count <= CW'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end

endmodule : rf_wr_fifo

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between the pipeline
// writeback stage and a buffered MDU result stream, with a starvation guard
// and a pending-write query for the hazard unit.
//   clk, rst                         clock, async active-low reset
//   pipe_valid/ready/addr/data       pipeline writeback handshake
//   mdu_valid/ready/addr/data        MDU result handshake into the FIFO
//   rf_a3, rf_wd3, rf_we3            registered write port to the RF
//   q_addr, q_pending                hazard query: write to q_addr still queued
//   fifo_count                       FIFO occupancy (debug)
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned ZERO_DISCARD = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_valid,
  output logic                   pipe_ready,
  input  logic [ADDR_W-1:0]      pipe_addr,
  input  logic [DATA_W-1:0]      pipe_data,
  input  logic                   mdu_valid,
  output logic                   mdu_ready,
  input  logic [ADDR_W-1:0]      mdu_addr,
  input  logic [DATA_W-1:0]      mdu_data,
  output logic [ADDR_W-1:0]      rf_a3,
  output logic [DATA_W-1:0]      rf_wd3,
  output logic                   rf_we3,
  input  logic [ADDR_W-1:0]      q_addr,
  output logic                   q_pending,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  wr_req_t                      mdu_req;
  wr_req_t                      pipe_req;
  wr_req_t                      head;
  wr_req_t                      sel;
  logic [DEPTH-1:0]             entry_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;
  logic [SW-1:0]                starve;
  logic                         fifo_busy;
  logic                         force_drain;
  logic                         pop;
  logic                         pipe_grant;
  logic                         issue;

  assign mdu_req.addr  = mdu_addr;
  assign mdu_req.data  = mdu_data;
  assign pipe_req.addr = pipe_addr;
  assign pipe_req.data = pipe_data;

  assign mdu_ready = (fifo_count < CW'(DEPTH));

  rf_wr_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (mdu_valid && mdu_ready),
    .push_req   (mdu_req),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .entry_valid(entry_valid),
    .entry_addr (entry_addr)
  );

  // Arbitration: pipeline wins unless the FIFO head has starved too long.
  assign fifo_busy   = (fifo_count != '0);
  assign force_drain = fifo_busy && (starve == SW'(STARVE_LIMIT));
  assign pipe_ready  = !force_drain;
  assign pop         = fifo_busy && (force_drain || !pipe_valid);
  assign pipe_grant  = pipe_valid && !force_drain;

  // Granted request and whether it actually reaches the RF (x0 is dropped).
  always_comb begin
    sel   = pop ? head : pipe_req;
    issue = pop || pipe_grant;
    if ((ZERO_DISCARD != 0) && (sel.addr == REG_ZERO)) issue = 1'b0;
  end

  // Starve counter: cycles the non-empty FIFO has lost, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve <= '0;
    end else if (!fifo_busy || pop) begin
      starve <= '0;
    end else if (starve != SW'(STARVE_LIMIT)) begin
      starve <= SW'(starve + 1'b1);
    end
  end

  // Issue register; address/data hold when nothing is written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we3 <= 1'b0;
      rf_a3  <= '0;
      rf_wd3 <= '0;
    end else begin
      rf_we3 <= issue;
      if (issue) begin
        rf_a3  <= sel.addr;
        rf_wd3 <= sel.data;
      end
    end
  end

  // Pending query covers queued entries and the write still in the register stage.
  always_comb begin
    q_pending = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (entry_valid[i] && (entry_addr[i] == q_addr)) q_pending = 1'b1;
    end
    if (rf_we3 && (rf_a3 == q_addr)) q_pending = 1'b1;
    if ((ZERO_DISCARD != 0) && (q_addr == REG_ZERO)) q_pending = 1'b0;
  end

endmodule : rf_write_arbiter
